// File: rtl/remap_pixel_fetch.sv
// Source-coordinate remap fetch: (x,y) -> frame-buffer read -> credit-gated FIFO -> AXI-Stream video.
// Accept to tvalid is RD_LAT+2 cycles. addr_rdy is withheld by credit, so reads never stall and the FIFO never overflows.
module remap_pixel_fetch #(
  parameter int          SRC_W      = 1920,
  parameter int          SRC_H      = 1080,
  parameter int          OUT_W      = 1080,
  parameter int          OUT_H      = 960,
  parameter int          RD_LAT     = 2,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] FILL       = 16'h0000,
  parameter int          ADDR_W     = $clog2(SRC_W*SRC_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_vld,
  output logic              addr_rdy,
  input  logic [11:0]       xIn,
  input  logic [11:0]       yIn,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rd_data,
  output logic [15:0]       AXIS_Out_tdata,
  output logic              AXIS_Out_tvalid,
  input  logic              AXIS_Out_tready,
  output logic              AXIS_Out_tuser,
  output logic              AXIS_Out_tlast
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int COLW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROWW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [12:0]       LP_SRC_W    = 13'(SRC_W);
  localparam logic [12:0]       LP_SRC_H    = 13'(SRC_H);
  localparam logic [ADDR_W-1:0] LP_PITCH    = ADDR_W'(SRC_W);
  localparam logic [CW-1:0]     LP_DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [COLW-1:0]   LP_COL_LAST = COLW'(OUT_W - 1);
  localparam logic [ROWW-1:0]   LP_ROW_LAST = ROWW'(OUT_H - 1);

  logic              w_acc;
  logic              w_oob;
  logic              w_push;
  logic              w_pop;
  logic [15:0]       w_push_dat;
  logic [ADDR_W-1:0] w_lin_addr;

  logic [CW-1:0]     r_used;
  logic [CW-1:0]     r_count;
  logic              r_s1_vld;
  logic              r_s1_oob;
  logic [ADDR_W-1:0] r_addr;
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_oob;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [15:0]       r_fifo [FIFO_DEPTH];
  logic [COLW-1:0]   r_col;
  logic [ROWW-1:0]   r_row;

  // r_used counts every pixel between accept and output transfer (pipe + FIFO).
  assign addr_rdy   = !reset && (r_used < LP_DEPTH);
  assign w_acc      = addr_vld && addr_rdy;
  assign w_oob      = ({1'b0, xIn} >= LP_SRC_W) || ({1'b0, yIn} >= LP_SRC_H);
  assign w_lin_addr = ADDR_W'(yIn) * LP_PITCH + ADDR_W'(xIn);

  assign mem_rd_en  = r_s1_vld && !r_s1_oob;
  assign mem_addr   = r_addr;

  assign w_push     = r_pipe_vld[RD_LAT-1];
  assign w_push_dat = r_pipe_oob[RD_LAT-1] ? FILL : mem_rd_data;
  assign w_pop      = AXIS_Out_tvalid && AXIS_Out_tready;

  assign AXIS_Out_tvalid = (r_count != '0);
  assign AXIS_Out_tdata  = AXIS_Out_tvalid ? r_fifo[r_rd_ptr] : 16'h0000;
  assign AXIS_Out_tuser  = AXIS_Out_tvalid && (r_col == '0) && (r_row == '0);
  assign AXIS_Out_tlast  = AXIS_Out_tvalid && (r_col == LP_COL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_used <= '0;
    end else begin
      case ({w_acc, w_pop})
        2'b10:   r_used <= r_used + CW'(1);
        2'b01:   r_used <= r_used - CW'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  // Out-of-range pixels ride the pipe with their oob flag but leave mem_addr untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
      r_s1_oob <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_s1_vld <= w_acc;
      r_s1_oob <= w_oob;
      if (w_acc && !w_oob) begin
        r_addr <= w_lin_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe_vld <= '0;
      r_pipe_oob <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_oob[i] <= r_pipe_oob[i-1];
      end
      r_pipe_vld[0] <= r_s1_vld;
      r_pipe_oob[0] <= r_s1_oob;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Raster position of the pixel currently presented on the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pop) begin
      if (r_col == LP_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == LP_ROW_LAST) ? '0 : r_row + ROWW'(1);
      end else begin
        r_col <= r_col + COLW'(1);
      end
    end
  end

endmodule

// File: tb/tb_remap_pixel_fetch.sv
// Randomised bench for remap_pixel_fetch: pixel-queue scoreboard plus directed latency/boundary/backpressure/reset checks.
module tb_remap_pixel_fetch;
  localparam int          SW   = 1920;
  localparam int          SH   = 1080;
  localparam int          OW   = 12;
  localparam int          OH   = 3;
  localparam int          RL   = 2;
  localparam int          D    = 8;
  localparam logic [15:0] FILL = 16'h0000;
  localparam int          AW   = $clog2(SW*SH);

  logic          clk = 1'b0;
  logic          reset;
  logic          addr_vld;
  logic          addr_rdy;
  logic [11:0]   xIn;
  logic [11:0]   yIn;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rd_data;
  logic [15:0]   tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;

  remap_pixel_fetch #(
    .SRC_W(SW), .SRC_H(SH), .OUT_W(OW), .OUT_H(OH),
    .RD_LAT(RL), .FIFO_DEPTH(D), .FILL(FILL), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .addr_vld(addr_vld), .addr_rdy(addr_rdy),
    .xIn(xIn), .yIn(yIn), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .AXIS_Out_tdata(tdata), .AXIS_Out_tvalid(tvalid),
    .AXIS_Out_tready(tready), .AXIS_Out_tuser(tuser), .AXIS_Out_tlast(tlast)
  );

  always #5 clk = ~clk;

  // Memory returns addr[15:0] RL cycles after the strobe, garbage otherwise.
  logic [15:0] mp_dat [RL];
  always @(posedge clk) begin
    mp_dat[0] <= mem_rd_en ? mem_addr[15:0] : 16'($urandom);
    for (int i = 1; i < RL; i++) mp_dat[i] <= mp_dat[i-1];
  end
  assign mem_rd_data = mp_dat[RL-1];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input int x, input int y);
    if (x >= SW || y >= SH) return FILL;
    return 16'((y * SW + x) & 32'hFFFF);
  endfunction

  // Scoreboard state: pixels accepted but not yet delivered, and delivered beat index.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          beat = 0;
  int          outstanding = 0;
  logic        exp_rd = 1'b0;
  int          exp_addr = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_dat;
  logic        prev_user, prev_last;
  int          acc_cnt = 0, pop_cnt = 0, rd_cnt = 0;
  int          tuser_cnt = 0, tlast_cnt = 0, rdy_low_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_tvalid", 32'(tvalid), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_rdy", 32'(addr_rdy), 32'd0);
      exp_q.delete();
      beat = 0;
      outstanding = 0;
      exp_rd = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("credit_rdy", 32'(addr_rdy), 32'(outstanding < D));
      chk("rd_en", 32'(mem_rd_en), 32'(exp_rd));
      if (exp_rd) chk("rd_addr", 32'(mem_addr), 32'(exp_addr));
      if (mem_rd_en) rd_cnt++;
      if (!addr_rdy) rdy_low_cnt++;
      if (prev_stall) begin
        chk("stall_tvalid", 32'(tvalid), 32'd1);
        chk("stall_tdata", 32'(tdata), 32'(prev_dat));
        chk("stall_tuser", 32'(tuser), 32'(prev_user));
        chk("stall_tlast", 32'(tlast), 32'(prev_last));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("beat_tdata", 32'(tdata), 32'(exp_q.pop_front()));
          chk("beat_tuser", 32'(tuser), 32'((beat % (OW*OH)) == 0));
          chk("beat_tlast", 32'(tlast), 32'((beat % OW) == OW - 1));
        end
        beat++;
        outstanding--;
        pop_cnt++;
        got_q.push_back(tdata);
        if (tuser) tuser_cnt++;
        if (tlast) tlast_cnt++;
      end
      prev_stall = tvalid && !tready;
      prev_dat = tdata;
      prev_user = tuser;
      prev_last = tlast;
      exp_rd = 1'b0;
      if (addr_vld && addr_rdy) begin
        exp_q.push_back(model_pix(int'(xIn), int'(yIn)));
        outstanding++;
        acc_cnt++;
        exp_rd = (int'(xIn) < SW) && (int'(yIn) < SH);
        exp_addr = int'(yIn) * SW + int'(xIn);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that took the coordinate.
  task automatic send(input int x, input int y);
    logic ok;
    int t;
    t = 0;
    ok = 1'b0;
    addr_vld = 1'b1;
    xIn = 12'(x);
    yIn = 12'(y);
    while (!ok && t < 1000) begin
      @(negedge clk);
      ok = addr_rdy;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
    addr_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (outstanding != 0 && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (outstanding != 0) chk("drain_timeout", 32'(outstanding), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    int acc0, pop0, rd0, n;
    reset = 1'b1; addr_vld = 1'b0; xIn = '0; yIn = '0; tready = 1'b1;

    chk("model_pin_a3ff", 32'(model_pix(1919, 1079)), 32'h0000A3FF);
    chk("model_pin_3843", 32'(model_pix(3, 2)), 32'd3843);
    chk("model_pin_oob", 32'(model_pix(1920, 0)), 32'(FILL));

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(addr_rdy), 32'd1);
    chk("post_rst_tvalid", 32'(tvalid), 32'd0);
    chk("post_rst_rd_en", 32'(mem_rd_en), 32'd0);

    // First-pixel latency: accept edge N, read in N+1, tvalid in N+4.
    @(posedge clk); #1 addr_vld = 1'b1; xIn = 12'd3; yIn = 12'd2;
    @(posedge clk); #1 addr_vld = 1'b0;
    @(negedge clk);
    chk("lat_rd_en", 32'(mem_rd_en), 32'd1);
    chk("lat_addr", 32'(mem_addr), 32'd3843);
    chk("lat_tvalid_n1", 32'(tvalid), 32'd0);
    @(negedge clk); chk("lat_tvalid_n2", 32'(tvalid), 32'd0);
    @(negedge clk); chk("lat_tvalid_n3", 32'(tvalid), 32'd0);
    @(negedge clk);
    chk("lat_tvalid_n4", 32'(tvalid), 32'd1);
    chk("lat_tdata", 32'(tdata), 32'h00000F03);
    chk("lat_tuser", 32'(tuser), 32'd1);
    wait_idle(50);

    // One complete output frame at full rate from the frame origin.
    do_reset();
    tuser_cnt = 0; tlast_cnt = 0; rdy_low_cnt = 0; pop0 = pop_cnt;
    for (int k = 0; k < OW*OH; k++) send(k, 0);
    wait_idle(100);
    chk("frame_beats", 32'(pop_cnt - pop0), 32'(OW*OH));
    chk("frame_tuser_cnt", 32'(tuser_cnt), 32'd1);
    chk("frame_tlast_cnt", 32'(tlast_cnt), 32'(OH));
    chk("frame_rdy_low", 32'(rdy_low_cnt), 32'd0);

    // Boundary coordinates: three out-of-range then the last in-range pixel.
    rd0 = rd_cnt;
    send(1920, 0); send(0, 1080); send(4095, 4095); send(1919, 1079);
    wait_idle(50);
    chk("oob_rd_count", 32'(rd_cnt - rd0), 32'd1);
    n = got_q.size();
    chk("oob_pix0", 32'(got_q[n-4]), 32'(FILL));
    chk("oob_pix1", 32'(got_q[n-3]), 32'(FILL));
    chk("oob_pix2", 32'(got_q[n-2]), 32'(FILL));
    chk("corner_pix", 32'(got_q[n-1]), 32'h0000A3FF);

    // Backpressure: credit must stop accepts at exactly FIFO_DEPTH.
    tready = 1'b0; acc0 = acc_cnt; pop0 = pop_cnt;
    addr_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      xIn = 12'($urandom_range(0, 2000));
      yIn = 12'($urandom_range(0, 1100));
      @(posedge clk); #1;
    end
    addr_vld = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 32'(acc_cnt - acc0), 32'(D));
    chk("bp_rdy_low", 32'(addr_rdy), 32'd0);
    @(posedge clk); #1 tready = 1'b1;
    wait_idle(50);
    chk("bp_drained", 32'(pop_cnt - pop0), 32'(D));

    // Random traffic over several frames with random backpressure.
    for (int i = 0; i < 600; i++) begin
      tready = 1'($urandom_range(0, 1));
      addr_vld = 1'($urandom_range(0, 1));
      xIn = 12'($urandom_range(0, 2100));
      yIn = 12'($urandom_range(0, 1200));
      @(posedge clk); #1;
    end
    addr_vld = 1'b0; tready = 1'b1;
    wait_idle(100);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with pixels in flight: everything discarded, next pixel starts a frame.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) send(100 + i, 10);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
    end
    chk("mid_rst_rdy", 32'(addr_rdy), 32'd1);
    @(posedge clk); #1;
    send(7, 7);
    n = 0;
    while (!tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_tvalid_seen", 32'(tvalid), 32'd1);
    chk("mid_rst_tuser", 32'(tuser), 32'd1);
    chk("mid_rst_tdata", 32'(tdata), 32'(model_pix(7, 7)));
    wait_idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
